// File: rtl/prbs_checker_if.sv
// ============================================================================
// Module      : prbs_checker_if
// Description : Receive-side bit stream and status bundle for prbs_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface prbs_checker_if #(
    parameter int CNT_W = 32
);
    logic             din_vld;
    logic             din;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output din_vld, din, clr,
        input  locked, err, bit_cnt, err_cnt
    );

    modport slave (
        input  din_vld, din, clr,
        output locked, err, bit_cnt, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/prbs_checker.sv
// ============================================================================
// Module      : prbs_checker
// Description : Self-synchronising checker for the 16-bit PRBS
//               (x^16 + x^14 + x^13 + x^11 + 1) with BER counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module prbs_checker #(
    parameter int LOCK_CNT = 32,
    parameter int ERR_WIN  = 64,
    parameter int ERR_THR  = 4,
    parameter int CNT_W    = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    prbs_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       c_LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0]      c_WIN_LAST  = 16'(ERR_WIN - 1);
    localparam logic [15:0]      c_ERR_LAST  = 16'(ERR_THR - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    state_t           r_state,    w_state_nxt;
    logic [15:0]      r_hist,     w_hist_nxt;
    logic [3:0]       r_fill,     w_fill_nxt;
    logic [7:0]       r_match,    w_match_nxt;
    logic [15:0]      r_win_bits, w_win_bits_nxt;
    logic [15:0]      r_win_errs, w_win_errs_nxt;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_pred;
    logic w_mis;
    logic w_bit_inc;
    logic w_err_inc;

    always_comb begin
        w_pred         = r_hist[15] ^ r_hist[4] ^ r_hist[2] ^ r_hist[1];
        w_mis          = bus.din ^ w_pred;
        w_state_nxt    = r_state;
        w_hist_nxt     = r_hist;
        w_fill_nxt     = r_fill;
        w_match_nxt    = r_match;
        w_win_bits_nxt = r_win_bits;
        w_win_errs_nxt = r_win_errs;
        w_bit_inc      = 1'b0;
        w_err_inc      = 1'b0;

        if (bus.din_vld) begin
            // Once locked the reference free-runs on its own prediction.
            w_hist_nxt = {r_hist[14:0], (r_state == ST_LOCKED) ? w_pred : bus.din};

            case (r_state)
                ST_SEED: begin
                    if (r_fill == 4'd15) begin
                        w_state_nxt = ST_VERIFY;
                        w_fill_nxt  = 4'd0;
                        w_match_nxt = 8'd0;
                    end else begin
                        w_fill_nxt = r_fill + 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (!w_mis && (r_hist != 16'd0)) begin
                        if (r_match == c_LOCK_LAST) begin
                            w_state_nxt    = ST_LOCKED;
                            w_match_nxt    = 8'd0;
                            w_win_bits_nxt = 16'd0;
                            w_win_errs_nxt = 16'd0;
                        end else begin
                            w_match_nxt = r_match + 8'd1;
                        end
                    end else begin
                        w_match_nxt = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    w_bit_inc = 1'b1;
                    w_err_inc = w_mis;
                    // Loss of lock outranks a window wrap on the same bit.
                    if (w_mis && (r_win_errs == c_ERR_LAST)) begin
                        w_state_nxt    = ST_SEED;
                        w_fill_nxt     = 4'd0;
                        w_win_bits_nxt = 16'd0;
                        w_win_errs_nxt = 16'd0;
                    end else if (r_win_bits == c_WIN_LAST) begin
                        w_win_bits_nxt = 16'd0;
                        w_win_errs_nxt = 16'd0;
                    end else begin
                        w_win_bits_nxt = r_win_bits + 16'd1;
                        w_win_errs_nxt = r_win_errs + {15'd0, w_mis};
                    end
                end
                default: begin
                    w_state_nxt = ST_SEED;
                    w_fill_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SEED;
            r_hist     <= 16'd0;
            r_fill     <= 4'd0;
            r_match    <= 8'd0;
            r_win_bits <= 16'd0;
            r_win_errs <= 16'd0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_bit_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hist     <= w_hist_nxt;
            r_fill     <= w_fill_nxt;
            r_match    <= w_match_nxt;
            r_win_bits <= w_win_bits_nxt;
            r_win_errs <= w_win_errs_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_err      <= w_err_inc;

            if (bus.clr) begin
                r_bit_cnt <= '0;
                r_err_cnt <= '0;
            end else begin
                if (w_bit_inc && (r_bit_cnt != '1))
                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                if (w_err_inc && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.locked  = r_locked;
    assign bus.err     = r_err;
    assign bus.bit_cnt = r_bit_cnt;
    assign bus.err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// Module      : tb_prbs_checker
// Description : Directed scoreboard bench for prbs_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prbs_checker;

    localparam int CNT_W = 32;
    localparam int GEN_N = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(CNT_W)) bus ();

    prbs_checker #(
        .LOCK_CNT (32),
        .ERR_WIN  (64),
        .ERR_THR  (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          ck_lock;
        bit          lock;
        bit          err;
        bit          ck_cnt;
        logic [31:0] bc;
        logic [31:0] ec;
        int          ph;
        int          idx;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    bit    gen [0:GEN_N-1];
    string ph_name [0:6] = '{"reset", "lock", "single", "loss", "twowin", "zeros", "vldtog"};

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at bit %0d: got %0d expected %0d", name, idx, act, req);
        end
    endtask

    function automatic exp_t mk(input int ph, input int idx, input bit ck_lock,
                                input bit lock, input bit ck_cnt,
                                input logic [31:0] bc, input logic [31:0] ec,
                                input bit err);
        exp_t e;
        e.ck_lock = ck_lock;
        e.lock    = lock;
        e.err     = err;
        e.ck_cnt  = ck_cnt;
        e.bc      = bc;
        e.ec      = ec;
        e.ph      = ph;
        e.idx     = idx;
        return e;
    endfunction

    task automatic drive(input bit vld, input bit d, input bit c, input exp_t e);
        @(negedge clk);
        bus.din_vld = vld;
        bus.din     = d;
        bus.clr     = c;
        sb_q.push_back(e);
    endtask

    // Outputs are sampled 2ns after the edge that consumed the stimulus.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.ck_lock)
                check({ph_name[mon_e.ph], ".locked"}, mon_e.idx, 32'(bus.locked), 32'(mon_e.lock));
            check({ph_name[mon_e.ph], ".err"}, mon_e.idx, 32'(bus.err), 32'(mon_e.err));
            if (mon_e.ck_cnt) begin
                check({ph_name[mon_e.ph], ".bit_cnt"}, mon_e.idx, bus.bit_cnt, mon_e.bc);
                check({ph_name[mon_e.ph], ".err_cnt"}, mon_e.idx, bus.err_cnt, mon_e.ec);
            end
        end
    end

    task automatic outputs_zero(input string name);
        check({name, ".locked"},  0, 32'(bus.locked), 32'd0);
        check({name, ".err"},     0, 32'(bus.err),    32'd0);
        check({name, ".bit_cnt"}, 0, bus.bit_cnt,     32'd0);
        check({name, ".err_cnt"}, 0, bus.err_cnt,     32'd0);
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        bus.din_vld = 1'b0;
        bus.din     = 1'b0;
        bus.clr     = 1'b0;
        #1;
        outputs_zero(name);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] seed_v;
        bit          inv;
        int          v;

        bus.din_vld = 1'b0;
        bus.din     = 1'b0;
        bus.clr     = 1'b0;

        seed_v = 16'h269F;
        for (int i = 0; i < 16; i++) gen[i] = seed_v[i];
        for (int i = 16; i < GEN_N; i++) gen[i] = gen[i-16] ^ gen[i-5] ^ gen[i-3] ^ gen[i-2];

        #12;
        outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream: lock after bit 48, bits 49..1000 counted.
        for (int n = 1; n <= 1000; n++)
            drive(1'b1, gen[n-1], 1'b0,
                  mk(1, n, 1'b1, (n >= 48), (n == 48 || n == 49 || n == 1000),
                     (n == 48) ? 32'd0 : (n == 49) ? 32'd1 : 32'd952, 32'd0, 1'b0));

        // One inverted bit: one err pulse, no multiplication.
        for (int n = 1001; n <= 1072; n++) begin
            inv = (n == 1020);
            drive(1'b1, gen[n-1] ^ inv, 1'b0,
                  mk(2, n, 1'b1, 1'b1, (n == 1020 || n == 1072),
                     (n == 1020) ? 32'd972 : 32'd1024, 32'd1, inv));
        end

        // Four errors in the window 1073..1136: lock lost at 1095, regained at 1143.
        for (int n = 1073; n <= 1143; n++) begin
            inv = (n == 1080 || n == 1085 || n == 1090 || n == 1095);
            drive(1'b1, gen[n-1] ^ inv, (n == 1075),
                  mk(3, n, 1'b1, (n < 1095) || (n >= 1143),
                     (n == 1075 || n == 1095 || n == 1143),
                     (n == 1075) ? 32'd0 : 32'd20, (n == 1075) ? 32'd0 : 32'd4, inv));
        end

        // Three errors in each of windows 1144..1207 and 1208..1271.
        for (int n = 1144; n <= 1280; n++) begin
            inv = (n == 1150 || n == 1160 || n == 1170 || n == 1210 || n == 1220 || n == 1230);
            drive(1'b1, gen[n-1] ^ inv, (n == 1145),
                  mk(4, n, 1'b1, 1'b1, (n == 1145 || n == 1207 || n == 1280),
                     (n == 1145) ? 32'd0 : (n == 1207) ? 32'd62 : 32'd135,
                     (n == 1145) ? 32'd0 : (n == 1207) ? 32'd3 : 32'd6, inv));
        end

        async_reset("rst_locked1");

        // All-zero stream never locks.
        for (int n = 1; n <= 500; n++)
            drive(1'b1, 1'b0, 1'b0, mk(5, n, 1'b1, 1'b0, (n == 500), 32'd0, 32'd0, 1'b0));
        // Generator after zeros: no lock before bit 33, locked by bit 48.
        for (int k = 1; k <= 60; k++)
            drive(1'b1, gen[k-1], 1'b0,
                  mk(5, 500 + k, (k <= 32) || (k >= 48), (k >= 48), 1'b0, 32'd0, 32'd0, 1'b0));

        async_reset("rst_locked2");

        // din_vld toggling; clr on valid bit 80 with lock held.
        v = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if ((cyc % 2) == 0) begin
                v++;
                drive(1'b1, gen[v-1], (v == 80),
                      mk(6, v, 1'b1, (v >= 48), (v == 48 || v == 79 || v == 80),
                         (v == 79) ? 32'd31 : 32'd0, 32'd0, 1'b0));
            end else begin
                drive(1'b0, ~gen[v], 1'b0,
                      mk(6, v, 1'b1, (v >= 48), (v == 100), 32'd20, 32'd0, 1'b0));
            end
        end

        async_reset("rst_locked3");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Serial receiver-side checker for the 16-bit PRBS stream produced by the team's LFSR generator.
- Feedback: out(n) = out(n-16) ^ out(n-5) ^ out(n-3) ^ out(n-2).
- Self-synchronises to the incoming bit stream with no shared seed, declares lock, then counts bit errors against a free-running local reference.
- Sits at the sink end of the serial link, e.g. after a loopback or channel model, to measure bit error rate.

Parameters:
LOCK_CNT, 32, consecutive correct predictions required in VERIFY before declaring lock (range 1..255)
ERR_WIN, 64, window length in valid bits for lock-loss evaluation while LOCKED (range 2..65535)
ERR_THR, 4, errors within one window that force loss of lock (range 1..ERR_WIN)
CNT_W, 32, width of the bit and error counters

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
din_vld  input  1  din is a valid received bit this cycle
din  input  1  received serial bit
clr  input  1  synchronous clear of bit_cnt and err_cnt; lock state unaffected
locked  output  1  checker is synchronised
err  output  1  one-cycle pulse: the bit sampled on the previous edge mismatched while LOCKED
bit_cnt  output  CNT_W  valid bits checked while LOCKED, saturating
err_cnt  output  CNT_W  mismatches while LOCKED, saturating

Behaviour:
- Reset values: state=SEED; hist=0; fill/match/window counters 0; locked=0, err=0, bit_cnt=0, err_cnt=0. Reset mid-operation aborts immediately to these values.
- hist[15:0]: hist[0] is the most recent bit.
- Prediction: pred = hist[15]^hist[4]^hist[2]^hist[1].
- Shift on every din_vld: hist <= {hist[14:0], in}.
  - in = din in SEED and VERIFY.
  - in = pred in LOCKED, so the reference free-runs and each channel error counts once.
- Cycles with din_vld=0 change nothing except clr.
- SEED:
  - Shift in din on each valid bit and count to 16.
  - On the 16th valid bit go to VERIFY.
- VERIFY, per valid bit:
  - din==pred and hist!=0: match count +1.
  - Mismatch: match count =0, stay in VERIFY. hist already holds the latest 16 received bits, so this is an implicit re-seed.
  - hist==0: match count held at 0. An all-zero stream never locks.
  - On the LOCK_CNT-th consecutive match: go to LOCKED, locked=1 after that edge.
- LOCKED, per valid bit:
  - bit_cnt +1.
  - If din!=pred: err_cnt +1, err=1 next cycle, window error count +1.
  - Window bit counter +1.
  - When it reaches ERR_WIN, both window counters clear on that edge.
  - If window errors reach ERR_THR: go to SEED, fill count 0, locked=0 after that edge.
  - Loss of lock takes priority over a window wrap on the same bit.
- err is registered: high exactly one cycle per mismatching valid bit in LOCKED, never in SEED/VERIFY.
- Counters saturate at all-ones; no wrap.
- clr: bit_cnt and err_cnt =0 on that edge. clr wins over a simultaneous increment. Window counters and state are unaffected.
- Latency: with continuous din_vld and a clean stream, locked rises after the edge sampling bit 16+LOCK_CNT (bit 48 at defaults).
- Outputs are registered; no combinational path from din to any output.

Test Plan:
- Generator output (reset seed 0x269F, first bits 1,1,1,1,1,0,0,1,0,1,1,0,0,1,0,0) fed with din_vld=1 -> locked rises after the 48th bit; err never pulses; bit_cnt=952 after 1000 bits; err_cnt=0.
- Locked clean stream, invert one bit -> single err pulse one cycle later; err_cnt=1; lock held; subsequent bits error-free (no error multiplication).
- Locked stream, invert 4 bits within 64 -> locked falls after the 4th; err_cnt=4; relock occurs 48 valid bits later.
- Invert 3 bits in each of two consecutive 64-bit windows -> locked stays 1; err_cnt=6.
- All-zero din for 500 bits -> locked stays 0. Then switch to generator output -> locks within 48 + 16 bits of the first nonzero bit.
- din_vld toggling 1/0 every cycle with clr asserted mid-run -> lock timing counts only valid bits; counters zero on the clr edge with lock retained. rst_n pulse while locked -> all outputs 0 asynchronously.
